expr_sig_collector: RTL and testbench

EXPR_SIG_COLLECTOR -- requirements
Module: expr_sig_collector

---
 rtl/expr_sig_pkg.sv | 17 +
 rtl/expr_sig_misr_step.sv | 21 ++
 rtl/expr_sig_collector.sv | 94 +++++++++
 tb/tb_expr_sig_collector.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/expr_sig_pkg.sv
// Shared types and constants for the expression-signature collector.
package expr_sig_pkg;

    localparam int SAMPLE_W = 90;
    localparam int SIG_W    = 32;
    localparam int CNT_W    = 16;

    localparam logic [SIG_W-1:0] DEF_POLY = 32'h04C11DB7;
    localparam logic [SIG_W-1:0] DEF_SEED = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/expr_sig_misr_step.sv
// One MISR step: shift/feedback the current signature and xor in the folded sample.
module expr_sig_misr_step
    import expr_sig_pkg::*;
#(
    parameter logic [SIG_W-1:0] POLY = DEF_POLY
) (
    input  logic [SIG_W-1:0]    sig_in,
    input  logic [SAMPLE_W-1:0] y_in,
    output logic [SIG_W-1:0]    sig_out
);

    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] feedback;

    // Compress the 90-bit sample to 32 bits; the top 26 bits are zero-extended.
    assign fold     = y_in[31:0] ^ y_in[63:32] ^ {6'b0, y_in[89:64]};
    // Galois-style feedback: the bit shifted out selects the polynomial.
    assign feedback = sig_in[SIG_W-1] ? POLY : '0;
    assign sig_out  = {sig_in[SIG_W-2:0], 1'b0} ^ feedback ^ fold;

endmodule

// File: rtl/expr_sig_collector.sv
// Collects NUM_SAMPLES expression results into a MISR signature and compares
// the result against a golden value.
module expr_sig_collector
    import expr_sig_pkg::*;
#(
    parameter int unsigned      NUM_SAMPLES = 256,
    parameter logic [SIG_W-1:0] POLY        = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED        = DEF_SEED
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_y,
    output logic                in_ready,
    input  logic [SIG_W-1:0]    exp_sig,
    output logic [SIG_W-1:0]    sig,
    output logic [CNT_W-1:0]    sample_cnt,
    output logic                done,
    output logic                match,
    output logic                overrun
);

    // Count value held just before the final accept of a run.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    state_t           state;
    state_t           state_next;
    logic [SIG_W-1:0] sig_step;
    logic             accept;
    logic             last_accept;

    expr_sig_misr_step #(
        .POLY (POLY)
    ) u_misr_step (
        .sig_in  (sig),
        .y_in    (in_y),
        .sig_out (sig_step)
    );

    assign in_ready    = (state == ST_COLLECT);
    // A start in the same cycle wins: the sample offered alongside it is dropped.
    assign accept      = in_valid && in_ready && !start;
    assign last_accept = accept && (sample_cnt == LAST_CNT);
    assign done        = (state == ST_DONE);
    assign match       = done && (sig == exp_sig);

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start restarts from any state, the final accept ends the run.
    // NOTE: the default assignment first guarantees no latch on any path.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_COLLECT;
        end else begin
            case (state)
                ST_COLLECT: if (last_accept) state_next = ST_DONE;
                default:    state_next = state;
            endcase
        end
    end

    // Signature, sample counter and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig        <= SEED;
            sample_cnt <= '0;
            overrun    <= 1'b0;
        end else if (start) begin
            sig        <= SEED;
            sample_cnt <= '0;
            overrun    <= 1'b0;
        end else begin
            if (accept) begin
                sig        <= sig_step;
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (in_valid && !in_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_expr_sig_collector.sv
// Self-checking bench for expr_sig_collector: directed steps plus random
// samples, checked against a transaction-level reference model.
module tb_expr_sig_collector;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;
    localparam int          RUN4 = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [89:0] in_y = '0;
    logic [31:0] exp_sig = '0;

    logic        rdy4, done4, match4, ovr4;
    logic [31:0] sig4;
    logic [15:0] cnt4;
    logic        rdy1, done1, match1, ovr1;
    logic [31:0] sig1;
    logic [15:0] cnt1;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state (transaction level).
    logic [89:0] q[$];
    logic        m_run  = 1'b0;
    logic        m_done = 1'b0;
    logic        m_ovr  = 1'b0;

    logic [31:0] saved_sig;
    logic [31:0] r;

    always #5 clk = ~clk;

    expr_sig_collector #(.NUM_SAMPLES(RUN4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_y(in_y), .in_ready(rdy4), .exp_sig(exp_sig), .sig(sig4),
        .sample_cnt(cnt4), .done(done4), .match(match4), .overrun(ovr4)
    );

    expr_sig_collector #(.NUM_SAMPLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_y(in_y), .in_ready(rdy1), .exp_sig(exp_sig), .sig(sig1),
        .sample_cnt(cnt1), .done(done1), .match(match1), .overrun(ovr1)
    );

    function automatic logic [89:0] rnd90();
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        return w[89:0];
    endfunction

    // Signature of the accepted samples, computed as polynomial arithmetic
    // over GF(2): multiply by x, reduce modulo x^32+POLY, add the folded word.
    function automatic logic [31:0] ref_sig();
        logic [32:0] t;
        logic [31:0] s;
        logic [89:0] y;
        s = SEED;
        for (int i = 0; i < q.size(); i++) begin
            y = q[i];
            t = {s, 1'b0};
            if (t[32]) t = t ^ {1'b1, POLY};
            s = t[31:0] ^ y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        r = ref_sig();
        chk({tag, ".sig"},      sig4,   r);
        chk({tag, ".cnt"},      {16'b0, cnt4}, q.size());
        chk({tag, ".done"},     {31'b0, done4},  {31'b0, m_done});
        chk({tag, ".overrun"},  {31'b0, ovr4},   {31'b0, m_ovr});
        chk({tag, ".in_ready"}, {31'b0, rdy4},   {31'b0, m_run});
        chk({tag, ".match"},    {31'b0, match4}, {31'b0, m_done && (r == exp_sig)});
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, release inputs.
    task automatic cyc(input logic s, input logic v, input logic [89:0] y);
        start = s; in_valid = v; in_y = y;
        @(posedge clk);
        if (s) begin
            q.delete(); m_run = 1'b1; m_done = 1'b0; m_ovr = 1'b0;
        end else if (m_run && v) begin
            q.push_back(y);
            if (q.size() == RUN4) begin m_run = 1'b0; m_done = 1'b1; end
        end else if (!m_run && v) begin
            m_ovr = 1'b1;
        end
        #1;
        start = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        // Reset state.
        #12;
        check_all("reset");
        chk("reset.ready1", {31'b0, rdy1}, 32'd0);
        rst_n = 1'b1;
        #3;

        // Single-sample run with a zero sample.
        exp_sig = 32'hFB3EE249;
        cyc(1'b1, 1'b0, '0);
        check_all("start1");
        chk("one.ready", {31'b0, rdy1}, 32'd1);
        cyc(1'b0, 1'b1, '0);
        chk("one.done",  {31'b0, done1},  32'd1);
        chk("one.sig",   sig1,            32'hFB3EE249);
        chk("one.cnt",   {16'b0, cnt1},   32'd1);
        chk("one.match", {31'b0, match1}, 32'd1);
        check_all("one.dut4");

        // Bubbled run of 4: valid toggles, done only after the 4th accept.
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, (i % 2) == 0, rnd90());
            if (i == 5) chk("bubble.not_done", {31'b0, done4}, 32'd0);
        end
        exp_sig = ref_sig();
        #1;
        check_all("bubble.done");
        chk("bubble.match", {31'b0, match4}, 32'd1);

        // Sample offered in DONE: overrun, nothing else moves.
        saved_sig = sig4;
        cyc(1'b0, 1'b1, 90'h1);
        check_all("done.overrun");
        chk("done.sig_hold", sig4, saved_sig);
        cyc(1'b1, 1'b0, '0);
        check_all("restart.clear");

        // Mid-run start abandons two samples; a sample in the start cycle is dropped.
        cyc(1'b0, 1'b1, rnd90());
        cyc(1'b0, 1'b1, rnd90());
        check_all("mid.two");
        cyc(1'b1, 1'b1, rnd90());
        check_all("mid.restart");
        chk("mid.seed", sig4, SEED);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, rnd90());
            check_all("mid.acc");
        end

        // One-bit miscompare.
        exp_sig = ref_sig() ^ (32'h1 << $urandom_range(0, 31));
        #1;
        check_all("miscompare");
        chk("miscompare.match", {31'b0, match4}, 32'd0);

        // Asynchronous reset mid-run.
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, rnd90());
        cyc(1'b0, 1'b1, rnd90());
        #2;
        rst_n = 1'b0;
        q.delete(); m_run = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
        #1;
        check_all("async_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, rnd90());
            check_all("post_rst");
        end
        cyc(1'b1, 1'b0, '0);
        check_all("post_rst.start");

        // Random runs with random bubbles and random golden values.
        for (int run = 0; run < 4; run++) begin
            cyc(1'b1, 1'b0, '0);
            for (int k = 0; k < 40 && m_run; k++) begin
                cyc(1'b0, $urandom_range(0, 1) == 1, rnd90());
                check_all("rand");
            end
            exp_sig = ($urandom_range(0, 1) == 1) ? ref_sig() : $urandom;
            #1;
            check_all("rand.end");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
